usb_proxy_dir_ctrl: RTL and testbench

USB_PROXY_DIR_CTRL -- requirements
Module: usb_proxy_dir_ctrl

---
 rtl/usb_proxy_dir_ctrl_if.sv | 27 ++
 rtl/usb_proxy_dir_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_usb_proxy_dir_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_proxy_dir_ctrl_if.sv
// Line-level bundle between the USB proxy direction controller and its pads.
// The pad side (master) drives raw line levels; the controller (slave) drives
// the direction, drive enables, forwarded levels and status.
interface usb_proxy_dir_ctrl_if;
    logic       host_dp_in;
    logic       host_dm_in;
    logic       dev_dp_in;
    logic       dev_dm_in;
    logic       dir;
    logic       host_oe;
    logic       dev_oe;
    logic       fwd_dp;
    logic       fwd_dm;
    logic       pkt_done;
    logic       timeout_err;
    logic [2:0] state;

    modport master (
        output host_dp_in, host_dm_in, dev_dp_in, dev_dm_in,
        input  dir, host_oe, dev_oe, fwd_dp, fwd_dm, pkt_done, timeout_err, state
    );

    modport slave (
        input  host_dp_in, host_dm_in, dev_dp_in, dev_dm_in,
        output dir, host_oe, dev_oe, fwd_dp, fwd_dm, pkt_done, timeout_err, state
    );
endinterface

// File: rtl/usb_proxy_dir_ctrl.sv
// USB full/low-speed proxy direction controller.
// Watches both sides of the link, picks the side that starts a packet,
// forwards its line levels to the other side, detects EOP (SE0 then J),
// drives a short forced J, then releases the bus for a blanking period.
module usb_proxy_dir_ctrl #(
    parameter int SE0_MIN     = 6,
    parameter int EOP_J_CLKS  = 4,
    parameter int TURN_CLKS   = 8,
    parameter int PKT_TIMEOUT = 40000
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_proxy_dir_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H2D   = 3'd1,
        D2H   = 3'd2,
        EOP_J = 3'd3,
        TURN  = 3'd4
    } state_t;

    // Synchronizer lane order: {host_dp, host_dm, dev_dp, dev_dm}; idle is J on both sides.
    localparam logic [3:0]  LINES_J    = 4'b1010;
    localparam logic [3:0]  SE0_THR    = 4'(SE0_MIN);
    localparam logic [15:0] EOP_LAST   = 16'(EOP_J_CLKS - 1);
    localparam logic [15:0] TURN_LAST  = 16'(TURN_CLKS - 1);
    localparam logic [15:0] TIMER_LAST = 16'(PKT_TIMEOUT - 1);

    logic [3:0]  sync1;
    logic [3:0]  sync2;
    state_t      st;
    logic        dir_q;
    logic        host_oe_q;
    logic        dev_oe_q;
    logic        fwd_dp_q;
    logic        fwd_dm_q;
    logic        pkt_done_q;
    logic        timeout_q;
    logic [3:0]  se0_cnt;
    logic [15:0] pkt_timer;
    logic [15:0] phase_cnt;

    logic host_dp_s;
    logic host_dm_s;
    logic dev_dp_s;
    logic dev_dm_s;
    logic host_start;
    logic dev_start;
    logic src_dp;
    logic src_dm;
    logic src_se0;

    // Two-flop synchronizer for all four raw line inputs, reset to J.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= LINES_J;
            sync2 <= LINES_J;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real stages.
            sync1 <= {bus.host_dp_in, bus.host_dm_in, bus.dev_dp_in, bus.dev_dm_in};
            sync2 <= sync1;
        end
    end

    assign host_dp_s = sync2[3];
    assign host_dm_s = sync2[2];
    assign dev_dp_s  = sync2[1];
    assign dev_dm_s  = sync2[0];

    // Host starts on K or SE0 (dp low); SE1 has dp high and so reads as J.
    assign host_start = ~host_dp_s;
    // Device starts on K only; a device SE0 while idle is ignored.
    assign dev_start  = ~dev_dp_s & dev_dm_s;

    // Source side of the current packet: device only while forwarding D2H.
    assign src_dp  = (st == D2H) ? dev_dp_s : host_dp_s;
    assign src_dm  = (st == D2H) ? dev_dm_s : host_dm_s;
    assign src_se0 = ~src_dp & ~src_dm;

    // Direction FSM with registered outputs, so start-to-oe is sync + one state clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every control register is reset; async reset drops both oe without a clock.
            st          <= IDLE;
            dir_q       <= 1'b0;
            host_oe_q   <= 1'b0;
            dev_oe_q    <= 1'b0;
            fwd_dp_q    <= 1'b1;
            fwd_dm_q    <= 1'b0;
            pkt_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            se0_cnt     <= 4'd0;
            pkt_timer   <= 16'd0;
            phase_cnt   <= 16'd0;
        end else begin
            pkt_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (st)
                IDLE: begin
                    se0_cnt   <= 4'd0;
                    pkt_timer <= 16'd0;
                    phase_cnt <= 16'd0;
                    if (host_start) begin
                        st        <= H2D;
                        dir_q     <= 1'b0;
                        dev_oe_q  <= 1'b1;
                        host_oe_q <= 1'b0;
                        fwd_dp_q  <= host_dp_s;
                        fwd_dm_q  <= host_dm_s;
                    end else if (dev_start) begin
                        st        <= D2H;
                        dir_q     <= 1'b1;
                        host_oe_q <= 1'b1;
                        dev_oe_q  <= 1'b0;
                        fwd_dp_q  <= dev_dp_s;
                        fwd_dm_q  <= dev_dm_s;
                    end else begin
                        dir_q     <= 1'b0;
                        host_oe_q <= 1'b0;
                        dev_oe_q  <= 1'b0;
                        fwd_dp_q  <= 1'b1;
                        fwd_dm_q  <= 1'b0;
                    end
                end

                H2D, D2H: begin
                    pkt_timer <= pkt_timer + 16'd1;
                    if (pkt_timer == TIMER_LAST) begin
                        // Runaway packet: abandon it without an EOP indication.
                        st        <= TURN;
                        timeout_q <= 1'b1;
                        host_oe_q <= 1'b0;
                        dev_oe_q  <= 1'b0;
                        fwd_dp_q  <= 1'b1;
                        fwd_dm_q  <= 1'b0;
                        phase_cnt <= 16'd0;
                    end else if (src_se0) begin
                        if (se0_cnt != 4'hF) begin
                            se0_cnt <= se0_cnt + 4'd1;
                        end
                        fwd_dp_q <= src_dp;
                        fwd_dm_q <= src_dm;
                    end else if (se0_cnt >= SE0_THR) begin
                        st         <= EOP_J;
                        pkt_done_q <= 1'b1;
                        fwd_dp_q   <= 1'b1;
                        fwd_dm_q   <= 1'b0;
                        phase_cnt  <= 16'd0;
                    end else begin
                        // J or K after a short SE0 glitch is just more packet data.
                        se0_cnt  <= 4'd0;
                        fwd_dp_q <= src_dp;
                        fwd_dm_q <= src_dm;
                    end
                end

                EOP_J: begin
                    fwd_dp_q <= 1'b1;
                    fwd_dm_q <= 1'b0;
                    if (phase_cnt == EOP_LAST) begin
                        st        <= TURN;
                        host_oe_q <= 1'b0;
                        dev_oe_q  <= 1'b0;
                        phase_cnt <= 16'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                TURN: begin
                    host_oe_q <= 1'b0;
                    dev_oe_q  <= 1'b0;
                    fwd_dp_q  <= 1'b1;
                    fwd_dm_q  <= 1'b0;
                    if (phase_cnt == TURN_LAST) begin
                        st        <= IDLE;
                        dir_q     <= 1'b0;
                        phase_cnt <= 16'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                default: begin
                    st        <= IDLE;
                    dir_q     <= 1'b0;
                    host_oe_q <= 1'b0;
                    dev_oe_q  <= 1'b0;
                    fwd_dp_q  <= 1'b1;
                    fwd_dm_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dir         = dir_q;
    assign bus.host_oe     = host_oe_q;
    assign bus.dev_oe      = dev_oe_q;
    assign bus.fwd_dp      = fwd_dp_q;
    assign bus.fwd_dm      = fwd_dm_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.state       = st;

endmodule

// File: tb/tb_usb_proxy_dir_ctrl.sv
// Bench for usb_proxy_dir_ctrl: table of packet scenarios, hand-written
// latency/glitch/reset sequences, and a randomized run compared cycle by
// cycle against a packet-level reference model.
module tb_usb_proxy_dir_ctrl;

    localparam int SE0_MIN     = 6;
    localparam int EOP_J_CLKS  = 4;
    localparam int TURN_CLKS   = 8;
    localparam int PKT_TIMEOUT = 100;

    // Line codes, packed as {dp, dm}.
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] host_lines = LJ;
    logic [1:0] dev_lines  = LJ;

    int checks_total  = 0;
    int checks_passed = 0;

    usb_proxy_dir_ctrl_if bus ();

    assign bus.host_dp_in = host_lines[1];
    assign bus.host_dm_in = host_lines[0];
    assign bus.dev_dp_in  = dev_lines[1];
    assign bus.dev_dm_in  = dev_lines[0];

    usb_proxy_dir_ctrl #(
        .SE0_MIN    (SE0_MIN),
        .EOP_J_CLKS (EOP_J_CLKS),
        .TURN_CLKS  (TURN_CLKS),
        .PKT_TIMEOUT(PKT_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on line classes and a packet "session"
    // (source side, clocks forwarded, SE0 run length, countdown of the
    // post-packet phases). Inputs reach decisions two clocks late.
    // ------------------------------------------------------------------
    localparam int C_J = 0, C_K = 1, C_SE0 = 2;

    function automatic int cls(input logic [1:0] l);
        if (l == LSE0) return C_SE0;
        if (l == LK)   return C_K;
        return C_J;
    endfunction

    logic [3:0] hist[$] = '{4'b1010, 4'b1010};
    int   m_mode = 0;
    int   m_src = 0;
    int   m_left = 0;
    int   m_run = 0;
    int   m_fwd_clks = 0;
    logic e_dir = 0, e_hoe = 0, e_doe = 0, e_done = 0, e_to = 0;
    logic [1:0] e_fwd = LJ;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist = '{4'b1010, 4'b1010};
                m_mode = 0; m_left = 0; m_run = 0; m_fwd_clks = 0;
                e_dir = 0; e_hoe = 0; e_doe = 0; e_done = 0; e_to = 0; e_fwd = LJ;
            end else begin
                logic [3:0] seen;
                logic [1:0] side[2];
                hist.push_back({host_lines, dev_lines});
                seen = hist.pop_front();
                side[0] = seen[3:2];
                side[1] = seen[1:0];
                e_done = 0;
                e_to = 0;
                if (m_mode == 0) begin
                    if (cls(side[0]) != C_J || cls(side[1]) == C_K) begin
                        m_src = (cls(side[0]) != C_J) ? 0 : 1;
                        m_mode = 1 + m_src;
                        m_fwd_clks = 0;
                        m_run = 0;
                        e_dir = (m_src == 1);
                        e_hoe = (m_src == 1);
                        e_doe = (m_src == 0);
                        e_fwd = side[m_src];
                    end else begin
                        e_dir = 0; e_hoe = 0; e_doe = 0; e_fwd = LJ;
                    end
                end else if (m_mode == 1 || m_mode == 2) begin
                    m_fwd_clks++;
                    if (m_fwd_clks == PKT_TIMEOUT) begin
                        m_mode = 4; m_left = TURN_CLKS; e_to = 1;
                        e_hoe = 0; e_doe = 0; e_fwd = LJ;
                    end else if (cls(side[m_src]) == C_SE0) begin
                        m_run++;
                        e_fwd = side[m_src];
                    end else if (m_run >= SE0_MIN) begin
                        m_mode = 3; m_left = EOP_J_CLKS; e_done = 1; e_fwd = LJ;
                    end else begin
                        m_run = 0;
                        e_fwd = side[m_src];
                    end
                end else if (m_mode == 3) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 4; m_left = TURN_CLKS; e_hoe = 0; e_doe = 0;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 0; e_dir = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cycle_outputs",
              {bus.state, bus.dir, bus.host_oe, bus.dev_oe, bus.fwd_dp, bus.fwd_dm,
               bus.pkt_done, bus.timeout_err},
              {3'(m_mode), e_dir, e_hoe, e_doe, e_fwd, e_done, e_to});
    end

    // Observation window for scenario-level expectations.
    int   pkt_cnt = 0;
    int   to_cnt = 0;
    logic seen_dir = 0, seen_hoe = 0, seen_doe = 0;

    always @(negedge clk) begin
        if (bus.pkt_done)    pkt_cnt++;
        if (bus.timeout_err) to_cnt++;
        seen_dir |= bus.dir;
        seen_hoe |= bus.host_oe;
        seen_doe |= bus.dev_oe;
    end

    task automatic clear_window();
        pkt_cnt = 0; to_cnt = 0; seen_dir = 0; seen_hoe = 0; seen_doe = 0;
    endtask

    task automatic step(input logic [1:0] h, input logic [1:0] d);
        @(negedge clk);
        host_lines = h;
        dev_lines  = d;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (3) step(LJ, LJ);
        while (bus.state != 3'd0 && n < 400) begin
            step(LJ, LJ);
            n++;
        end
        check({name, "_back_to_idle"}, bus.state, 3'd0);
    endtask

    typedef struct {
        string name;
        int    src;       // 0 host, 1 device, 2 both on the same clock
        int    k_clks;
        int    se0_clks;
        int    exp_done;
        int    exp_to;
        logic  exp_dir;
        logic  exp_hoe;
        logic  exp_doe;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input vec_t v);
        logic [1:0] hk, dk, hs, ds;
        hk = (v.src != 1) ? LK : LJ;
        dk = (v.src != 0) ? LK : LJ;
        hs = (v.src != 1) ? LSE0 : LJ;
        ds = (v.src != 0) ? LSE0 : LJ;
        clear_window();
        repeat (v.k_clks) step(hk, dk);
        repeat (v.se0_clks) step(hs, ds);
        wait_idle(v.name);
        check({v.name, "_pkt_done"}, pkt_cnt, v.exp_done);
        check({v.name, "_timeout"}, to_cnt, v.exp_to);
        check({v.name, "_dir"}, seen_dir, v.exp_dir);
        check({v.name, "_host_oe"}, seen_hoe, v.exp_hoe);
        check({v.name, "_dev_oe"}, seen_doe, v.exp_doe);
    endtask

    function automatic logic [1:0] pick(input int r);
        if (r < 4) return LJ;
        if (r < 7) return LK;
        if (r < 9) return LSE0;
        return LSE1;
    endfunction

    initial begin
        //           name              src  K    SE0 done to dir hoe doe
        vecs[0]  = '{"host_pkt",        0,  12,  8,  1,  0, 0,  0,  1};
        vecs[1]  = '{"dev_pkt",         1,  12,  7,  1,  0, 1,  1,  0};
        vecs[2]  = '{"both_start",      2,  12,  8,  1,  0, 0,  0,  1};
        vecs[3]  = '{"se0_short",       0,  12,  5,  0,  1, 0,  0,  1};
        vecs[4]  = '{"se0_min",         0,  12,  6,  1,  0, 0,  0,  1};
        vecs[5]  = '{"dev_se0_short",   1,  10,  5,  0,  1, 1,  1,  0};
        vecs[6]  = '{"host_bus_reset",  0,   0, 20,  1,  0, 0,  0,  1};
        vecs[7]  = '{"dev_se0_ignored", 1,   0, 10,  0,  0, 0,  0,  0};
        vecs[8]  = '{"held_k_timeout",  0, 105,  0,  0,  1, 0,  0,  1};
        vecs[9]  = '{"eop_at_last_clk", 0,  93,  6,  1,  0, 0,  0,  1};
        vecs[10] = '{"eop_vs_timeout",  0,  94,  6,  0,  1, 0,  0,  1};

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_state", bus.state, 3'd0);
        check("rst_oe", {bus.host_oe, bus.dev_oe, bus.dir}, 3'b000);
        check("rst_fwd", {bus.fwd_dp, bus.fwd_dm}, 2'b10);
        check("rst_pulses", {bus.pkt_done, bus.timeout_err}, 2'b00);
        rst = 1'b0;

        // Start-to-oe latency straight after reset release.
        step(LK, LJ);
        @(negedge clk) check("lat_clk1_dev_oe", bus.dev_oe, 1'b0);
        @(negedge clk) check("lat_clk2_dev_oe", bus.dev_oe, 1'b0);
        @(negedge clk) check("lat_clk3_dev_oe", bus.dev_oe, 1'b1);
        check("lat_clk3_state", bus.state, 3'd1);
        repeat (8) step(LSE0, LJ);
        wait_idle("latency");

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // SE0 glitch mid-packet is data; a later full EOP closes the packet.
        clear_window();
        repeat (5) step(LK, LJ);
        repeat (3) step(LSE0, LJ);
        repeat (5) step(LK, LJ);
        check("glitch_still_h2d", bus.state, 3'd1);
        check("glitch_no_done", pkt_cnt, 0);
        repeat (6) step(LSE0, LJ);
        wait_idle("glitch");
        check("glitch_done_once", pkt_cnt, 1);

        // Asynchronous reset in the middle of an H2D packet.
        clear_window();
        repeat (6) step(LK, LJ);
        check("pre_rst_dev_oe", bus.dev_oe, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_dev_oe", bus.dev_oe, 1'b0);
        check("async_rst_state", bus.state, 3'd0);
        check("async_rst_fwd", {bus.fwd_dp, bus.fwd_dm}, 2'b10);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) check("rel_clk1_dev_oe", bus.dev_oe, 1'b0);
        @(negedge clk) check("rel_clk2_dev_oe", bus.dev_oe, 1'b0);
        @(negedge clk) check("rel_clk3_dev_oe", bus.dev_oe, 1'b1);
        check("rel_no_pulses", pkt_cnt + to_cnt, 0);
        repeat (8) step(LSE0, LJ);
        wait_idle("after_reset");

        // Randomized line activity on both sides, checked every cycle by the model.
        for (int s = 0; s < 300; s++) begin
            logic [1:0] h, d;
            int len;
            h = pick($urandom_range(0, 9));
            d = pick($urandom_range(0, 9));
            len = $urandom_range(1, 10);
            repeat (len) step(h, d);
        end
        wait_idle("random");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
